// File: rtl/cbb_comm_pkg.sv
// Shared types and helpers for the cbb_comm datapath blocks.
package cbb_comm_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAcc
  } state_e;

  // Sign-extend the low w bits of v to 64 bits; callers truncate to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] t;
    t = v << (64 - w);
    return t >>> (64 - w);
  endfunction

  // True when a full-length window can never wrap the accumulator.
  function automatic bit acc_width_ok(input int unsigned acc_w, input int unsigned in_w,
                                      input int unsigned len_w);
    return acc_w >= in_w + len_w;
  endfunction

endpackage

// File: rtl/int_dump_acc.sv
// Integrate-and-dump accumulator: sums len_q valid signed samples per window and emits
// one ACC_WIDTH-bit sum, with a sticky wrap flag, one cycle after the last sample.
module int_dump_acc
  import cbb_comm_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync,
  input  logic [LEN_WIDTH-1:0] dump_len,
  input  logic                 din_vld,
  input  logic [IN_WIDTH-1:0]  din,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_vld,
  output logic                 ovf
);

  // With a wide enough accumulator a window cannot wrap, so the detector folds away.
  localparam bit AccNoWrap = acc_width_ok(ACC_WIDTH, IN_WIDTH, LEN_WIDTH);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ovf_w_q, ovf_w_d;
  logic                 dout_vld_q, dout_vld_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] din_x;
  logic [ACC_WIDTH-1:0] sum;
  logic [LEN_WIDTH-1:0] len_new;
  logic                 add_ovf;
  logic                 last;

  assign din_x   = ACC_WIDTH'(sext(64'(din), IN_WIDTH));
  assign sum     = acc_q + din_x;
  assign len_new = (dump_len == '0) ? LEN_WIDTH'(1) : dump_len;
  assign add_ovf = AccNoWrap ? 1'b0 :
                   (acc_q[ACC_WIDTH-1] == din_x[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign last    = (cnt_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_w_d    = ovf_w_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ovf_d      = 1'b0;

    if (sync) begin
      // Restart from either state; a coincident sample opens the new window.
      state_d = StAcc;
      len_d   = len_new;
      ovf_w_d = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
      if (din_vld) begin
        if (len_new == LEN_WIDTH'(1)) begin
          dout_d     = din_x;
          dout_vld_d = 1'b1;
        end else begin
          acc_d = din_x;
          cnt_d = LEN_WIDTH'(1);
        end
      end
    end else if (state_q == StAcc && din_vld) begin
      if (last) begin
        dout_d     = sum;
        dout_vld_d = 1'b1;
        ovf_d      = ovf_w_q | add_ovf;
        ovf_w_d    = 1'b0;
        acc_d      = '0;
        cnt_d      = '0;
        len_d      = len_new;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + LEN_WIDTH'(1);
        ovf_w_d = ovf_w_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= LEN_WIDTH'(1);
      ovf_w_q    <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_w_q    <= ovf_w_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_int_dump_acc.sv
// Bench for int_dump_acc: a 32-bit and a 16-bit accumulator share one stimulus stream.
module tb_int_dump_acc;
  import cbb_comm_pkg::*;

  typedef struct {
    longint e32;
    longint o32;
    longint e16;
    longint o16;
    int     due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b0;
  logic [7:0]  dump_len = 8'd0;
  logic        din_vld = 1'b0;
  logic [15:0] din = 16'd0;
  logic [31:0] dout32;
  logic        dv32, ovf32;
  logic [15:0] dout16;
  logic        dv16, ovf16;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  int_dump_acc u_dut (
    .clk(clk), .rst(rst), .sync(sync), .dump_len(dump_len), .din_vld(din_vld), .din(din),
    .dout(dout32), .dout_vld(dv32), .ovf(ovf32)
  );

  int_dump_acc #(.IN_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(8)) u_dut16 (
    .clk(clk), .rst(rst), .sync(sync), .dump_len(dump_len), .din_vld(din_vld), .din(din),
    .dout(dout16), .dout_vld(dv16), .ovf(ovf16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit s, input bit v, input int d, input int l);
    @(posedge clk);
    #1;
    sync     = s;
    din_vld  = v;
    din      = 16'(d);
    dump_len = 8'(l);
  endtask

  task automatic push(input longint e32, input longint o32, input longint e16,
                      input longint o16);
    exp_t e;
    e.e32 = e32; e.o32 = o32; e.e16 = e16; e.o16 = o16;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Scoreboard: every dump pulse must match the head of the queue, on its due cycle.
  always @(negedge clk) begin
    if (dv32 || dv16) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_dump: got dv32=%0b dv16=%0b expected no pulse", dv32, dv16);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("dv32", longint'(dv32), 1);
        check("dv16", longint'(dv16), 1);
        check("dout32", longint'($signed(dout32)), e.e32);
        check("ovf32", longint'(ovf32), e.o32);
        check("dout16", longint'($signed(dout16)), e.e16);
        check("ovf16", longint'(ovf16), e.o16);
        check("latency", longint'(cyc), longint'(e.due));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout32", longint'(dout32), 0);
    check("rst_vld32", longint'(dv32), 0);
    check("rst_ovf16", longint'(ovf16), 0);
    check("rst_state", longint'(u_dut.state_q), longint'(StIdle));
    rst = 1'b1;

    // Basic window of four
    step(1, 0, 0, 4);
    step(0, 1, 100, 4);
    step(0, 1, -50, 4);
    step(0, 1, 25, 4);
    step(0, 1, 7, 4);
    push(82, 0, 82, 0);
    repeat (3) step(0, 0, 0, 4);
    check("hold_dout32", longint'($signed(dout32)), 82);
    check("vld_pulse", longint'(dv32), 0);

    // Gaps in valid
    step(1, 0, 0, 3);
    step(0, 1, 1000, 3);
    step(0, 0, 0, 3);
    step(0, 1, 1000, 3);
    check("gap_acc", longint'(u_dut.acc_q), 1000);
    check("gap_cnt", longint'(u_dut.cnt_q), 1);
    step(0, 0, 0, 3);
    step(0, 1, 1000, 3);
    push(3000, 0, 3000, 0);
    step(0, 0, 0, 3);

    // Length 0 behaves as 1: back-to-back dumps
    step(1, 1, -5, 0);
    push(-5, 0, -5, 0);
    step(0, 1, 9, 0);
    push(9, 0, 9, 0);
    step(0, 1, -32768, 0);
    push(-32768, 0, -32768, 0);
    step(0, 0, 0, 0);

    // Wrap: only the 16-bit accumulator overflows
    step(1, 0, 0, 2);
    step(0, 1, 32767, 2);
    step(0, 1, 1, 2);
    push(32768, 0, -32768, 1);
    step(0, 1, 1, 2);
    step(0, 1, 1, 2);
    push(2, 0, 2, 0);
    step(0, 0, 0, 2);

    // Sync mid-window discards the partial sum
    step(1, 0, 0, 4);
    step(0, 1, 10, 4);
    step(0, 1, 10, 4);
    step(1, 1, 10, 4);
    step(0, 1, 10, 4);
    step(0, 1, 10, 4);
    step(0, 1, 10, 4);
    push(40, 0, 40, 0);
    step(0, 0, 0, 4);
    step(0, 0, 0, 4);
    check("hold_dout16", longint'($signed(dout16)), 40);

    // Mid-window reset aborts and returns to idle
    step(1, 0, 0, 4);
    step(0, 1, 5, 4);
    step(0, 1, 5, 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    din_vld = 1'b0;
    check("mrst_dout32", longint'(dout32), 0);
    check("mrst_dout16", longint'(dout16), 0);
    check("mrst_state", longint'(u_dut.state_q), longint'(StIdle));
    check("mrst_acc", longint'(u_dut.acc_q), 0);
    check("mrst_len", longint'(u_dut16.len_q), 1);
    repeat (4) step(0, 1, 7, 1);
    repeat (4) step(0, 0, 0, 1);
    check("mrst_dout_idle", longint'(dout32), 0);
    check("queue_empty", longint'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_dump_acc.md
Name: int_dump_acc

Overview:
- Integrate-and-dump accumulator that sums N consecutive valid signed samples and emits one wide sum per window.
- Sits directly upstream of the 32-to-16 saturation stage in the cbb_comm datapath.
- Its ACC_WIDTH-bit output feeds the saturation stage's din unchanged, so that stage bounds the result to 16 bits.
- Window length is runtime-programmable and can be re-aligned to a frame strobe.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- ACC_WIDTH, 32, accumulator and output width; must be at least IN_WIDTH + LEN_WIDTH.
- LEN_WIDTH, 8, width of the dump-length control.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- sync  in  1  one-cycle window-restart strobe.
- dump_len  in  LEN_WIDTH  samples per window; value 0 is treated as 1.
- din_vld  in  1  sample qualifier.
- din  in  IN_WIDTH  signed two's-complement sample.
- dout  out  ACC_WIDTH  signed window sum.
- dout_vld  out  1  one-cycle pulse; dout is valid in this cycle.
- ovf  out  1  pulses with dout_vld when the window sum wrapped.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, acc=0, cnt=0, len_q=1, dout=0, dout_vld=0, ovf=0. Reset wins over every other input and aborts any partial window without emitting it.
- States are IDLE and ACC only.
- IDLE: din_vld is ignored. On sync=1 go to ACC, latch len_q = max(dump_len, 1), set acc=0, cnt=0.
- Same-cycle sync and din_vld, in IDLE or ACC: that sample is the first of the new window. acc=sext(din), cnt=1. If len_q_new==1, dump immediately.
- ACC with din_vld=1 and sync=0:
  - sum = acc + sext(din), computed at ACC_WIDTH with two's-complement wrap.
  - If cnt == len_q-1, this is the window end: dout<=sum, dout_vld<=1 on the next cycle, acc<=0, cnt<=0, and len_q re-latched from dump_len. The block stays in ACC, so windows run back-to-back.
  - Otherwise acc<=sum, cnt<=cnt+1.
- ACC with din_vld=0: acc and cnt hold. Gaps in valid are allowed at any point.
- ACC with sync=1: the partial window is discarded without output, and len_q is re-latched.
- dump_len changes mid-window take effect only at the next window boundary or sync.
- Latency: dout_vld is high exactly 1 cycle after the din_vld cycle carrying the last sample of the window.
- dout holds its value until the next dump. dout_vld and ovf are single-cycle pulses.
- Overflow detection:
  - An addition overflows when both operand signs are equal and the result sign differs.
  - A sticky ovf_w is set on any overflow within the window, including the final addition.
  - ovf<=ovf_w at the dump; ovf_w clears at the dump, at sync and at reset.
- Throughput: one sample per cycle with no bubbles. Back-to-back dumps with len_q=1 give dout_vld high on consecutive cycles.
- cnt width is LEN_WIDTH. Maximum window is 2^LEN_WIDTH-1 samples, and cnt never wraps because it clears at len_q-1.

Decomposition:
- Shared package cbb_comm_pkg holds:
  - the state enum {IDLE, ACC};
  - the sign-extension helper function;
  - the localparam check ACC_WIDTH >= IN_WIDTH+LEN_WIDTH, as an elaboration assertion.
- No sub-module is required; one always block for control and one for the datapath.
- At system level this block instantiates next to the saturation stage with matching ACC_WIDTH = IN_WIDTH of that stage.

Test Plan:
- Reset then sync, dump_len=4, din = 100, -50, 25, 7 on consecutive cycles -> one cycle after the 4th sample: dout_vld=1, dout=82, ovf=0. No other dout_vld pulses.
- dump_len=3, din=1000 every other cycle (valid gaps) -> dout=3000 one cycle after the 3rd valid sample. acc and cnt are unchanged during the gaps.
- dump_len=0, din = -5, 9, -32768 back-to-back -> dout_vld on 3 consecutive cycles with dout = -5, 9, -32768 (treated as len 1).
- ACC_WIDTH=16 variant, dump_len=2, din=32767, 1 -> dout=-32768 (0x8000), ovf=1. The next window of 1, 1 gives dout=2, ovf=0.
- dump_len=4; sync pulses after 2 samples, coincident with a third sample of 10; then 3 more samples of 10 -> the partial window is discarded and dout=40 once.
- Mid-window rst=0 for 1 cycle after 2 samples -> all outputs 0 and state IDLE. Subsequent din_vld without sync produces no dout_vld.
